hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 74 +++++++
 tb/tb_hazard_scoreboard.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-GPR Tnew/stage tracking that drives the D-stage stall,
// the operand forward source and a saturating stall-cycle counter.
module hazard_scoreboard #(
  parameter int NREG  = 32,
  parameter int AW    = 5,
  parameter int TW    = 3,
  parameter int DEPTH = 3,
  parameter int AGE_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d_valid,
  input  logic [AW-1:0]    d_rs,
  input  logic [AW-1:0]    d_rt,
  input  logic [TW-1:0]    d_rs_tuse,
  input  logic [TW-1:0]    d_rt_tuse,
  input  logic             d_regwrite,
  input  logic [AW-1:0]    d_dst,
  input  logic [TW-1:0]    d_tnew,
  input  logic             d_md,
  input  logic             md_busy,
  input  logic             md_start,
  input  logic             d_eret,
  input  logic             d_mtc0_epc,
  input  logic             flush,
  output logic             stall,
  output logic [AGE_W-1:0] fwd_rs,
  output logic [AGE_W-1:0] fwd_rt,
  output logic [31:0]      stall_cnt
);
  localparam int NA = 1 << AW;
  localparam int EW = DEPTH > 1 ? DEPTH - 1 : 1;
  localparam logic [TW-1:0] UNUSED = '1;
  logic [NA-1:0]    valid;
  logic [TW-1:0]    tnew [NA];
  logic [AGE_W-1:0] age [NA];
  logic [EW-1:0]    epc;
  logic issue, rs_haz, rt_haz, md_haz, eret_haz;
  assign issue = d_valid & ~stall & ~flush;
  // Register 0 and indices beyond NREG are held permanently empty.
  always_ff @(posedge clk)
    for (int i = 0; i < NA; i++)
      if (reset || i == 0 || i >= NREG) begin
        valid[i] <= 1'b0;
        tnew[i]  <= '0;
        age[i]   <= '0;
      end else if (issue && d_regwrite && d_dst == AW'(i)) begin
        valid[i] <= 1'b1;
        tnew[i]  <= d_tnew;
        age[i]   <= AGE_W'(1);
      end else if (valid[i] && (flush || age[i] == AGE_W'(DEPTH))) begin
        valid[i] <= 1'b0;
        tnew[i]  <= '0;
        age[i]   <= '0;
      end else if (valid[i]) begin
        age[i]  <= age[i] + 1'b1;
        tnew[i] <= tnew[i] - TW'(tnew[i] != '0);
      end
  always_ff @(posedge clk)
    if (reset || flush) epc <= '0;
    else epc <= (epc << 1) | EW'(issue & d_mtc0_epc);
  always_ff @(posedge clk)
    if (reset) stall_cnt <= '0;
    else if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
  always_comb begin
    rs_haz   = d_rs != '0 && d_rs_tuse != UNUSED && valid[d_rs] && tnew[d_rs] > d_rs_tuse;
    rt_haz   = d_rt != '0 && d_rt_tuse != UNUSED && valid[d_rt] && tnew[d_rt] > d_rt_tuse;
    md_haz   = d_md & (md_busy | md_start);
    eret_haz = d_eret & (|epc);
    stall    = d_valid & (rs_haz | rt_haz | md_haz | eret_haz);
    fwd_rs   = (d_rs != '0 && valid[d_rs] && tnew[d_rs] == '0) ? age[d_rs] : '0;
    fwd_rt   = (d_rt != '0 && valid[d_rt] && tnew[d_rt] == '0) ? age[d_rt] : '0;
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scenarios plus random traffic checked against
// an in-flight instruction pipeline model.
module tb_hazard_scoreboard;
  localparam int NREG = 32, AW = 5, TW = 3, DEPTH = 3, AGE_W = 2;
  localparam int NOUSE = (1 << TW) - 1;
  logic clk = 1'b0, reset = 1'b1;
  logic d_valid, d_regwrite, d_md, md_busy, md_start, d_eret, d_mtc0_epc, flush;
  logic [AW-1:0] d_rs, d_rt, d_dst;
  logic [TW-1:0] d_rs_tuse, d_rt_tuse, d_tnew;
  logic stall;
  logic [AGE_W-1:0] fwd_rs, fwd_rt;
  logic [31:0] stall_cnt;
  int errors = 0, checks = 0;
  longint scnt = 0;
  typedef struct packed {bit v; bit wr; bit mtc0; int dst; int tnew;} ins_t;
  ins_t pipe [1:DEPTH];

  hazard_scoreboard #(.NREG(NREG), .AW(AW), .TW(TW), .DEPTH(DEPTH), .AGE_W(AGE_W)) dut (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
    .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse), .d_regwrite(d_regwrite), .d_dst(d_dst),
    .d_tnew(d_tnew), .d_md(d_md), .md_busy(md_busy), .md_start(md_start), .d_eret(d_eret),
    .d_mtc0_epc(d_mtc0_epc), .flush(flush), .stall(stall), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt),
    .stall_cnt(stall_cnt));

  always #5 clk = ~clk;

  // Model: pipe[k] is the instruction in post-D stage k; Tnew shrinks by one per stage.
  function automatic int rem(int k);
    return pipe[k].tnew - (k - 1) > 0 ? pipe[k].tnew - (k - 1) : 0;
  endfunction
  function automatic int youngest(int r);
    for (int k = 1; k <= DEPTH; k++) if (pipe[k].v && pipe[k].wr && pipe[k].dst == r) return k;
    return 0;
  endfunction
  function automatic bit haz(int r, int tuse);
    int k = youngest(r);
    return r != 0 && tuse != NOUSE && k != 0 && rem(k) > tuse;
  endfunction
  function automatic int m_fwd(int r);
    int k = youngest(r);
    return (r != 0 && k != 0 && rem(k) == 0) ? k : 0;
  endfunction
  function automatic bit m_stall();
    bit epc = 0;
    for (int k = 1; k < DEPTH; k++) epc |= pipe[k].v & pipe[k].mtc0;
    return d_valid & (haz(int'(d_rs), int'(d_rs_tuse)) | haz(int'(d_rt), int'(d_rt_tuse)) |
                      (d_md & (md_busy | md_start)) | (d_eret & epc));
  endfunction

  task automatic tick();
    bit st = m_stall();
    bit iss = d_valid & ~st & ~flush;
    ins_t ni = '{v: 1'b1, wr: d_regwrite && d_dst != 0, mtc0: d_mtc0_epc, dst: int'(d_dst), tnew: int'(d_tnew)};
    @(posedge clk);
    if (reset) begin
      for (int k = 1; k <= DEPTH; k++) pipe[k] = '0;
      scnt = 0;
    end else begin
      if (st && scnt < 64'hFFFFFFFF) scnt++;
      for (int k = DEPTH; k > 1; k--) pipe[k] = pipe[k-1];
      pipe[1] = iss ? ni : '0;
      if (flush) for (int k = 1; k <= DEPTH; k++) pipe[k] = '0;
    end
    #1;
  endtask

  task automatic drive(input bit v, input int rs, rt, rs_t, rt_t, input bit rw, input int dst, tn);
    d_valid = v; d_rs = AW'(rs); d_rt = AW'(rt); d_rs_tuse = TW'(rs_t); d_rt_tuse = TW'(rt_t);
    d_regwrite = rw; d_dst = AW'(dst); d_tnew = TW'(tn);
    d_md = 0; md_busy = 0; md_start = 0; d_eret = 0; d_mtc0_epc = 0; flush = 0;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, NOUSE, NOUSE, 0, 0, 0);
    reset = 1; tick(); tick(); reset = 0;
    for (int n = 0; n < 4; n++) begin
      drive(1, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 6), $urandom_range(0, 6), 0, 0, 0);
      #1; checks++;
      if (stall !== 1'b0 || fwd_rs !== '0 || fwd_rt !== '0 || stall_cnt !== '0) begin
        errors++; $display("FAIL reset_idle: got stall=%b fwd_rs=%0d fwd_rt=%0d cnt=%0d want 0 0 0 0", stall, fwd_rs, fwd_rt, stall_cnt);
      end
    end
  endtask

  task automatic test_load_use();
    drive(1, 0, 0, NOUSE, NOUSE, 1, 8, 2); tick();
    drive(1, 8, 0, 1, NOUSE, 0, 0, 0);
    for (int c = 0; c < 4; c++) begin
      #1; checks++;
      if (stall !== m_stall() || fwd_rs !== AGE_W'(m_fwd(8))) begin
        errors++; $display("FAIL load_use c%0d: got stall=%b fwd=%0d want %b %0d", c, stall, fwd_rs, m_stall(), m_fwd(8));
      end
      tick();
    end
  endtask

  task automatic test_alu_branch();
    drive(1, 0, 0, NOUSE, NOUSE, 1, 9, 1); tick();
    drive(1, 9, 0, 0, NOUSE, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      #1; checks++;
      if (stall !== m_stall() || fwd_rs !== AGE_W'(m_fwd(9))) begin
        errors++; $display("FAIL alu_branch c%0d: got stall=%b fwd=%0d want %b %0d", c, stall, fwd_rs, m_stall(), m_fwd(9));
      end
      tick();
    end
    drive(1, 0, 0, NOUSE, NOUSE, 1, 0, 1); tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 2; c++) begin
      #1; checks++;
      if (stall !== 1'b0 || fwd_rs !== '0 || fwd_rt !== '0) begin
        errors++; $display("FAIL zero_dst c%0d: got stall=%b fwd=%0d/%0d want 0 0/0", c, stall, fwd_rs, fwd_rt);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    drive(1, 0, 0, NOUSE, NOUSE, 1, 5, 2); tick();
    drive(1, 0, 0, NOUSE, NOUSE, 1, 5, 1); tick();
    drive(1, 5, 5, 1, 0, 0, 0, 0);
    for (int c = 0; c < 4; c++) begin
      #1; checks++;
      if (stall !== m_stall() || fwd_rs !== AGE_W'(m_fwd(5)) || fwd_rt !== AGE_W'(m_fwd(5))) begin
        errors++; $display("FAIL back_to_back c%0d: got stall=%b fwd=%0d/%0d want %b %0d", c, stall, fwd_rs, fwd_rt, m_stall(), m_fwd(5));
      end
      tick();
    end
  endtask

  task automatic test_flush();
    drive(1, 0, 0, NOUSE, NOUSE, 1, 7, 2); tick();
    drive(1, 0, 0, NOUSE, NOUSE, 1, 10, 3); flush = 1; tick();
    drive(1, 7, 10, 0, 0, 0, 0, 0);
    #1; checks++;
    if (stall !== 1'b0 || fwd_rs !== '0 || fwd_rt !== '0) begin
      errors++; $display("FAIL flush: got stall=%b fwd_rs=%0d fwd_rt=%0d want 0 0 0", stall, fwd_rs, fwd_rt);
    end
    tick();
  endtask

  task automatic test_eret_md();
    drive(1, 0, 0, NOUSE, NOUSE, 0, 0, 0); d_mtc0_epc = 1; tick();
    drive(1, 0, 0, NOUSE, NOUSE, 0, 0, 0); d_eret = 1;
    for (int c = 0; c < 3; c++) begin
      #1; checks++;
      if (stall !== m_stall()) begin
        errors++; $display("FAIL eret c%0d: got stall=%b want %b", c, stall, m_stall());
      end
      tick();
    end
    drive(1, 0, 0, NOUSE, NOUSE, 0, 0, 0); d_md = 1; md_busy = 1;
    for (int c = 0; c < 5; c++) begin
      #1; checks++;
      if (stall !== 1'b1) begin
        errors++; $display("FAIL md_busy c%0d: got stall=%b want 1", c, stall);
      end
      tick();
    end
    md_busy = 0; md_start = 1;
    #1; checks++;
    if (stall !== 1'b1 || stall_cnt !== 32'(scnt)) begin
      errors++; $display("FAIL md_start: got stall=%b cnt=%0d want 1 %0d", stall, stall_cnt, scnt);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 0, NOUSE, NOUSE, 1, 1, 3); tick();
    drive(1, 0, 0, NOUSE, NOUSE, 1, 2, 3); tick();
    drive(1, 0, 0, NOUSE, NOUSE, 1, 3, 3); tick();
    drive(1, 1, 2, 0, 0, 0, 0, 0); reset = 1; tick(); reset = 0;
    #1; checks++;
    if (stall !== 1'b0 || fwd_rs !== '0 || fwd_rt !== '0 || stall_cnt !== '0) begin
      errors++; $display("FAIL reset_mid: got stall=%b fwd=%0d/%0d cnt=%0d want 0 0/0 0", stall, fwd_rs, fwd_rt, stall_cnt);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 4) == 4 ? NOUSE : $urandom_range(0, 3),
            $urandom_range(0, 4) == 4 ? NOUSE : $urandom_range(0, 3),
            $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 4));
      d_md = $urandom_range(0, 5) == 0; md_busy = $urandom_range(0, 1) == 1; md_start = $urandom_range(0, 3) == 0;
      d_eret = $urandom_range(0, 4) == 0; d_mtc0_epc = $urandom_range(0, 4) == 0;
      flush = $urandom_range(0, 19) == 0; reset = $urandom_range(0, 79) == 0;
      #1; checks++;
      if (stall !== m_stall() || fwd_rs !== AGE_W'(m_fwd(int'(d_rs))) ||
          fwd_rt !== AGE_W'(m_fwd(int'(d_rt))) || stall_cnt !== 32'(scnt)) begin
        errors++;
        $display("FAIL random n%0d: got stall=%b fwd=%0d/%0d cnt=%0d want %b %0d/%0d %0d", n, stall, fwd_rs, fwd_rt,
                 stall_cnt, m_stall(), m_fwd(int'(d_rs)), m_fwd(int'(d_rt)), scnt);
      end
      tick();
    end
    reset = 0;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_alu_branch();
    test_back_to_back();
    test_flush();
    test_eret_md();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
